// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the instruction/data cache memory arbiter:
// FSM states, memory op codes and requester identities.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

  typedef enum logic {
    PORT_IC = 1'b0,
    PORT_DC = 1'b1
  } port_t;

endpackage

// File: rtl/memory_arbiter_rr.sv
// Two-way round-robin grant selection between the instruction and data caches.
// The last-grant pointer advances only when the owner accepts the grant.
module round_robin_arbiter_2
  import memory_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  ic_req,
  input  logic  dc_req,
  input  logic  accept,
  output logic  grant_valid,
  output port_t grant
);

  port_t last_grant;

  always_comb begin
    // NOTE: every output gets a default first, so no path through this block infers a latch.
    grant_valid = ic_req | dc_req;
    grant       = PORT_IC;
    if (ic_req && dc_req) begin
      grant = (last_grant == PORT_IC) ? PORT_DC : PORT_IC;
    end else if (dc_req) begin
      grant = PORT_DC;
    end
  end

  // Pointing at the instruction cache out of reset lets the data cache win the first contest.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= PORT_IC;
    end else if (accept && grant_valid) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates one shared line-wide memory port between a read-only instruction
// cache and a read/write data cache, with a per-operation watchdog.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDRESS_SIZE    = 12,
  parameter int CACHE_LINE_SIZE = 128,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ic_req,
  input  logic [ADDRESS_SIZE-1:0]    ic_address,
  output logic [CACHE_LINE_SIZE-1:0] ic_data_out,
  output logic                       ic_ready,
  input  logic                       dc_req,
  input  logic                       dc_op,
  input  logic [ADDRESS_SIZE-1:0]    dc_address,
  input  logic [CACHE_LINE_SIZE-1:0] dc_data_in,
  output logic [CACHE_LINE_SIZE-1:0] dc_data_out,
  output logic                       dc_ready,
  output logic                       mem_enable,
  output logic                       mem_op,
  output logic [ADDRESS_SIZE-1:0]    mem_address,
  output logic [CACHE_LINE_SIZE-1:0] mem_data_in,
  output logic                       mem_op_init,
  output logic                       mem_op_done,
  input  logic [CACHE_LINE_SIZE-1:0] mem_data_out,
  input  logic                       mem_data_ready,
  output logic                       busy,
  output logic                       timeout_error
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_t      state;
  port_t           granted;
  logic [WD_W-1:0] wd_count;
  logic            grant_valid;
  port_t           grant;

  round_robin_arbiter_2 u_rr (
    .clk         (clk),
    .reset       (reset),
    .ic_req      (ic_req),
    .dc_req      (dc_req),
    .accept      (state == IDLE),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      granted       <= PORT_IC;
      wd_count      <= '0;
      ic_data_out   <= '0;
      ic_ready      <= 1'b0;
      dc_data_out   <= '0;
      dc_ready      <= 1'b0;
      mem_enable    <= 1'b0;
      mem_op        <= OP_READ;
      mem_address   <= '0;
      mem_data_in   <= '0;
      mem_op_init   <= 1'b0;
      mem_op_done   <= 1'b0;
      busy          <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      // Pulse outputs fall back to zero unless this edge raises them.
      ic_ready      <= 1'b0;
      dc_ready      <= 1'b0;
      timeout_error <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_valid) begin
            granted     <= grant;
            state       <= ISSUE;
            busy        <= 1'b1;
            mem_enable  <= 1'b1;
            mem_op_init <= 1'b1;
            if (grant == PORT_DC) begin
              mem_address <= dc_address;
              mem_op      <= dc_op;
              mem_data_in <= dc_data_in;
            end else begin
              mem_address <= ic_address;
              mem_op      <= OP_READ;
              mem_data_in <= '0;
            end
          end
        end

        ISSUE: begin
          state    <= WAIT;
          wd_count <= '0;
        end

        WAIT: begin
          if (mem_data_ready) begin
            if (mem_op == OP_READ) begin
              if (granted == PORT_DC) dc_data_out <= mem_data_out;
              else                    ic_data_out <= mem_data_out;
            end
            if (granted == PORT_DC) dc_ready <= 1'b1;
            else                    ic_ready <= 1'b1;
            mem_enable  <= 1'b0;
            mem_op_init <= 1'b0;
            mem_op_done <= 1'b1;
            state       <= DONE;
          end else if (wd_count == WD_LAST) begin
            timeout_error <= 1'b1;
            mem_enable    <= 1'b0;
            mem_op_init   <= 1'b0;
            mem_op_done   <= 1'b1;
            state         <= DONE;
          end else begin
            wd_count <= wd_count + 1'b1;
          end
        end

        DONE: begin
          // Wait for memory to release its ready so one response is never counted twice.
          mem_op_done <= 1'b0;
          if (!mem_data_ready) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: a randomized-latency memory responder
// plus a transaction-level reference of memory contents and round-robin order.
module tb_memory_arbiter;

  localparam int AW = 12;
  localparam int LW = 128;
  localparam int TO = 64;

  logic          clk;
  logic          reset;
  logic          ic_req;
  logic [AW-1:0] ic_address;
  logic [LW-1:0] ic_data_out;
  logic          ic_ready;
  logic          dc_req;
  logic          dc_op;
  logic [AW-1:0] dc_address;
  logic [LW-1:0] dc_data_in;
  logic [LW-1:0] dc_data_out;
  logic          dc_ready;
  logic          mem_enable;
  logic          mem_op;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_data_in;
  logic          mem_op_init;
  logic          mem_op_done;
  logic [LW-1:0] mem_data_out;
  logic          mem_data_ready;
  logic          busy;
  logic          timeout_error;

  memory_arbiter #(
    .ADDRESS_SIZE    (AW),
    .CACHE_LINE_SIZE (LW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ic_req         (ic_req),
    .ic_address     (ic_address),
    .ic_data_out    (ic_data_out),
    .ic_ready       (ic_ready),
    .dc_req         (dc_req),
    .dc_op          (dc_op),
    .dc_address     (dc_address),
    .dc_data_in     (dc_data_in),
    .dc_data_out    (dc_data_out),
    .dc_ready       (dc_ready),
    .mem_enable     (mem_enable),
    .mem_op         (mem_op),
    .mem_address    (mem_address),
    .mem_data_in    (mem_data_in),
    .mem_op_init    (mem_op_init),
    .mem_op_done    (mem_op_done),
    .mem_data_out   (mem_data_out),
    .mem_data_ready (mem_data_ready),
    .busy           (busy),
    .timeout_error  (timeout_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [LW-1:0] mem_model [int];
  logic [LW-1:0] ref_mem   [int];
  bit            mem_auto = 1'b1;
  bit            last_dc;
  logic [LW-1:0] exp_ic;
  logic [LW-1:0] exp_dc;

  function automatic logic [LW-1:0] default_line(input logic [AW-1:0] a);
    return {4{20'h5A5A5, a}};
  endfunction

  function automatic logic [LW-1:0] ref_read(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return default_line(a);
  endfunction

  // Memory responder: ready comes 1..4 cycles after the operation is seen, for one cycle.
  initial begin
    int lat;
    bit in_op;
    lat = 0;
    in_op = 1'b0;
    mem_data_ready = 1'b0;
    mem_data_out = '0;
    forever begin
      @(negedge clk);
      if (mem_data_ready) begin
        mem_data_ready = 1'b0;
      end else if (!mem_enable) begin
        in_op = 1'b0;
      end else if (!in_op) begin
        in_op = 1'b1;
        lat = int'($urandom_range(1, 4));
      end else if (mem_auto) begin
        lat--;
        if (lat == 0) begin
          in_op = 1'b0;
          if (mem_op) mem_model[int'(mem_address)] = mem_data_in;
          else mem_data_out = mem_model.exists(int'(mem_address)) ?
                              mem_model[int'(mem_address)] : default_line(mem_address);
          mem_data_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    ic_req = 1'b0;
    dc_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    last_dc = 1'b0;
    exp_ic = '0;
    exp_dc = '0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 20) begin
      tick();
      c++;
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL wait_idle busy got %b want 0 after %0d cycles", busy, c);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if ({mem_enable, mem_op, mem_op_init, mem_op_done, busy, timeout_error, ic_ready, dc_ready} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ctrl got %b want 00000000",
               {mem_enable, mem_op, mem_op_init, mem_op_done, busy, timeout_error, ic_ready, dc_ready});
    end
    n_vec++;
    if (mem_address !== '0 || mem_data_in !== '0) begin
      n_err++;
      $display("FAIL reset_mem_bus got addr=%h data=%h want 0", mem_address, mem_data_in);
    end
    n_vec++;
    if (ic_data_out !== '0 || dc_data_out !== '0) begin
      n_err++;
      $display("FAIL reset_data_out got ic=%h dc=%h want 0", ic_data_out, dc_data_out);
    end
  endtask

  // One request on one port, dropped after the grant edge; inputs are scrambled afterwards.
  task automatic do_txn(input bit to_dc, input bit op, input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
    logic [LW-1:0] exp_line;
    int bad_drive;
    bit seen;
    bit wr;
    wr = to_dc && op;
    exp_line = ref_read(addr);
    if (wr) ref_mem[int'(addr)] = wdata;
    ic_req = !to_dc;
    dc_req = to_dc;
    ic_address = addr;
    dc_address = addr;
    dc_op = wr;
    dc_data_in = wdata;
    tick();
    ic_req = 1'b0;
    dc_req = 1'b0;
    ic_address = AW'($urandom);
    dc_address = AW'($urandom);
    dc_op = 1'($urandom);
    dc_data_in = {$urandom, $urandom, $urandom, $urandom};
    bad_drive = 0;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (ic_ready || dc_ready) begin
        seen = 1'b1;
        break;
      end
      if (mem_enable) begin
        if (mem_address !== addr || mem_op !== wr || mem_op_init !== 1'b1 || (wr && mem_data_in !== wdata))
          bad_drive++;
      end
      tick();
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL txn_ready addr=%h got no ready want one within 200 cycles", addr);
    end
    n_vec++;
    if (bad_drive != 0) begin
      n_err++;
      $display("FAIL txn_drive addr=%h got %0d bad cycles (addr=%h op=%b) want 0", addr, bad_drive, mem_address, mem_op);
    end
    n_vec++;
    if ({ic_ready, dc_ready} !== (to_dc ? 2'b01 : 2'b10) || mem_op_done !== 1'b1) begin
      n_err++;
      $display("FAIL txn_port addr=%h got ic_rdy=%b dc_rdy=%b done=%b want port_dc=%b done=1",
               addr, ic_ready, dc_ready, mem_op_done, to_dc);
    end
    if (!wr) begin
      if (to_dc) exp_dc = exp_line;
      else       exp_ic = exp_line;
    end
    n_vec++;
    if (ic_data_out !== exp_ic || dc_data_out !== exp_dc) begin
      n_err++;
      $display("FAIL txn_data addr=%h got ic=%h dc=%h want ic=%h dc=%h", addr, ic_data_out, dc_data_out, exp_ic, exp_dc);
    end
    last_dc = to_dc;
    tick();
    n_vec++;
    if ({ic_ready, dc_ready, mem_op_done} !== 3'b000) begin
      n_err++;
      $display("FAIL txn_pulse addr=%h got rdy=%b%b done=%b want 000", addr, ic_ready, dc_ready, mem_op_done);
    end
    wait_idle();
  endtask

  // Both caches hold their requests; completions must alternate starting opposite the last winner.
  task automatic serve_both(input int n);
    logic [AW-1:0] a_ic, a_dc;
    bit idle_seen;
    bit exp_port_dc;
    int got;
    a_ic = AW'($urandom_range(16'h100, 16'h1FF));
    a_dc = AW'($urandom_range(16'h200, 16'h2FF));
    ic_address = a_ic;
    dc_address = a_dc;
    dc_op = 1'b0;
    ic_req = 1'b1;
    dc_req = 1'b1;
    got = 0;
    idle_seen = 1'b0;
    for (int c = 0; c < n * 100 && got < n; c++) begin
      tick();
      if (busy === 1'b0) idle_seen = 1'b1;
      if (ic_ready || dc_ready) begin
        exp_port_dc = !last_dc;
        n_vec++;
        if ({ic_ready, dc_ready} !== (exp_port_dc ? 2'b01 : 2'b10)) begin
          n_err++;
          $display("FAIL rr_order #%0d got ic_rdy=%b dc_rdy=%b want port_dc=%b", got, ic_ready, dc_ready, exp_port_dc);
        end
        if (got > 0) begin
          n_vec++;
          if (!idle_seen) begin
            n_err++;
            $display("FAIL rr_idle_gap #%0d got no busy=0 cycle want at least one", got);
          end
        end
        if (exp_port_dc) exp_dc = ref_read(a_dc);
        else             exp_ic = ref_read(a_ic);
        n_vec++;
        if (ic_data_out !== exp_ic || dc_data_out !== exp_dc) begin
          n_err++;
          $display("FAIL rr_data #%0d got ic=%h dc=%h want ic=%h dc=%h", got, ic_data_out, dc_data_out, exp_ic, exp_dc);
        end
        last_dc = exp_port_dc;
        idle_seen = 1'b0;
        got++;
      end
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
    n_vec++;
    if (got != n) begin
      n_err++;
      $display("FAIL rr_count got %0d completions want %0d", got, n);
    end
    wait_idle();
  endtask

  task automatic test_ic_read();
    logic [LW-1:0] line;
    line = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    mem_model[16'h010] = line;
    ref_mem[16'h010] = line;
    do_txn(1'b0, 1'b0, 12'h010, '0);
  endtask

  task automatic test_dc_write();
    do_txn(1'b1, 1'b1, 12'h020, {16{8'hA5}});
    do_txn(1'b1, 1'b0, 12'h020, '0);
  endtask

  task automatic test_same_cycle();
    apply_reset();
    serve_both(2);
  endtask

  task automatic test_round_robin();
    do_txn(1'b0, 1'b0, AW'($urandom_range(0, 15)), '0);
    serve_both(6);
  endtask

  task automatic test_timeout();
    int en_cnt;
    bit ready_seen;
    bit fired;
    mem_auto = 1'b0;
    ic_req = 1'b1;
    ic_address = 12'h055;
    tick();
    ic_req = 1'b0;
    en_cnt = 0;
    ready_seen = 1'b0;
    fired = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (timeout_error) begin
        fired = 1'b1;
        break;
      end
      if (mem_enable) en_cnt++;
      if (ic_ready || dc_ready) ready_seen = 1'b1;
      tick();
    end
    n_vec++;
    if (!fired) begin
      n_err++;
      $display("FAIL to_pulse got no timeout_error want one within 200 cycles");
    end
    n_vec++;
    if (en_cnt != TO + 1) begin
      n_err++;
      $display("FAIL to_length got %0d enabled cycles want %0d (issue + %0d wait)", en_cnt, TO + 1, TO);
    end
    n_vec++;
    if (ready_seen || {ic_ready, dc_ready, mem_enable, mem_op_init, mem_op_done} !== 5'b00001) begin
      n_err++;
      $display("FAIL to_outputs got ready_seen=%b rdy=%b%b en=%b init=%b done=%b want no ready, done=1",
               ready_seen, ic_ready, dc_ready, mem_enable, mem_op_init, mem_op_done);
    end
    tick();
    n_vec++;
    if (timeout_error !== 1'b0 || ic_ready !== 1'b0) begin
      n_err++;
      $display("FAIL to_one_shot got timeout_error=%b ic_ready=%b want 0 0", timeout_error, ic_ready);
    end
    wait_idle();
    last_dc = 1'b0;
    n_vec++;
    if (ic_data_out !== exp_ic) begin
      n_err++;
      $display("FAIL to_data_held got %h want %h", ic_data_out, exp_ic);
    end
    mem_auto = 1'b1;
  endtask

  task automatic test_reset_mid();
    mem_auto = 1'b0;
    dc_req = 1'b1;
    dc_op = 1'b1;
    dc_address = 12'h0AB;
    dc_data_in = {$urandom, $urandom, $urandom, $urandom};
    tick();
    dc_req = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    last_dc = 1'b0;
    exp_ic = '0;
    exp_dc = '0;
    n_vec++;
    if ({mem_enable, mem_op_init, mem_op_done, busy, ic_ready, dc_ready, timeout_error} !== 7'b0) begin
      n_err++;
      $display("FAIL rst_mid_ctrl got en=%b init=%b done=%b busy=%b rdy=%b%b to=%b want all 0",
               mem_enable, mem_op_init, mem_op_done, busy, ic_ready, dc_ready, timeout_error);
    end
    n_vec++;
    if (ic_data_out !== '0 || dc_data_out !== '0) begin
      n_err++;
      $display("FAIL rst_mid_data got ic=%h dc=%h want 0", ic_data_out, dc_data_out);
    end
    mem_auto = 1'b1;
    tick();
    serve_both(2);
  endtask

  task automatic test_random();
    bit to_dc;
    bit op;
    for (int i = 0; i < 24; i++) begin
      to_dc = 1'($urandom);
      op = to_dc ? 1'($urandom) : 1'b0;
      do_txn(to_dc, op, AW'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom});
    end
  endtask

  initial begin
    reset = 1'b1;
    ic_req = 1'b0;
    ic_address = '0;
    dc_req = 1'b0;
    dc_op = 1'b0;
    dc_address = '0;
    dc_data_in = '0;
    test_reset();
    test_ic_read();
    test_dc_write();
    test_same_cycle();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
